alu_arbiter: RTL



---
 rtl/alu_arbiter_if.sv | 40 ++++
 rtl/alu_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response signals of alu_arbiter.
// slave is the arbiter's view; master is the surrounding logic's view.
interface alu_arbiter_if;
  localparam int unsigned OPND_W = 4;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned RES_W  = 8;
  localparam int unsigned CNT_W  = 8;

  logic              reqValid0, reqValid1;
  logic              reqReady0, reqReady1;
  logic [OPND_W-1:0] reqOperandA0, reqOperandA1;
  logic [OPND_W-1:0] reqOperandB0, reqOperandB1;
  logic [OP_W-1:0]   reqOperation0, reqOperation1;
  logic [OPND_W-1:0] aluOperandA, aluOperandB;
  logic [OP_W-1:0]   aluOperation;
  logic [RES_W-1:0]  aluResult;
  logic              aluZeroFlag;
  logic              respValid, respReady, respId;
  logic [RES_W-1:0]  respResult;
  logic              respZero, respError;
  logic [CNT_W-1:0]  grantCount0, grantCount1;

  modport slave (
    input  reqValid0, reqValid1, reqOperandA0, reqOperandA1,
           reqOperandB0, reqOperandB1, reqOperation0, reqOperation1,
           aluResult, aluZeroFlag, respReady,
    output reqReady0, reqReady1, aluOperandA, aluOperandB, aluOperation,
           respValid, respId, respResult, respZero, respError,
           grantCount0, grantCount1
  );

  modport master (
    output reqValid0, reqValid1, reqOperandA0, reqOperandA1,
           reqOperandB0, reqOperandB1, reqOperation0, reqOperation1,
           aluResult, aluZeroFlag, respReady,
    input  reqReady0, reqReady1, aluOperandA, aluOperandB, aluOperation,
           respValid, respId, respResult, respZero, respError,
           grantCount0, grantCount1
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 4-bit ALU between two requesters (IDLE/EXEC/RESP).
// Optional grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);
  localparam int unsigned OPND_W = 4;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned RES_W  = 8;
  localparam int unsigned CNT_W  = 8;
  localparam logic [OP_W-1:0] OP_MAX = OP_W'(4);

  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic [OP_W-1:0]   op;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             grant_c;
  logic             accept_c;
  logic             ready0_c, ready1_c;
  cmd_t             sel_c;
  logic             sel_illegal_c;
  cmd_t             alu_q;
  logic             cmd_id, cmd_err;
  logic             resp_valid, resp_id, resp_zero, resp_error;
  logic [RES_W-1:0] resp_result;

  // Single valid requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_c = bus.reqValid1;
    if (bus.reqValid0 && bus.reqValid1) grant_c = ~last_grant;
  end

  always_comb begin
    sel_c = grant_c ? cmd_t'{bus.reqOperandA1, bus.reqOperandB1, bus.reqOperation1}
                    : cmd_t'{bus.reqOperandA0, bus.reqOperandB0, bus.reqOperation0};
    sel_illegal_c = (sel_c.op > OP_MAX);
  end

  assign accept_c = (state == IDLE) && (bus.reqValid0 || bus.reqValid1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready0_c  = 1'b0;
    ready1_c  = 1'b0;
    case (state)
      IDLE: begin
        ready0_c = bus.reqValid0 && !grant_c;
        ready1_c = bus.reqValid1 && grant_c;
        if (bus.reqValid0 || bus.reqValid1) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.respReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU inputs are only non-zero during EXEC and never for an illegal opcode.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant  <= 1'b1;
      cmd_id      <= 1'b0;
      cmd_err     <= 1'b0;
      alu_q       <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            last_grant <= grant_c;
            cmd_id     <= grant_c;
            cmd_err    <= sel_illegal_c;
            alu_q      <= sel_illegal_c ? '0 : sel_c;
          end
        end
        EXEC: begin
          alu_q       <= '0;
          resp_valid  <= 1'b1;
          resp_id     <= cmd_id;
          resp_error  <= cmd_err;
          resp_result <= cmd_err ? '0 : bus.aluResult;
          resp_zero   <= cmd_err ? 1'b0 : bus.aluZeroFlag;
        end
        RESP: begin
          if (bus.respReady) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.reqReady0    = ready0_c;
  assign bus.reqReady1    = ready1_c;
  assign bus.aluOperandA  = alu_q.a;
  assign bus.aluOperandB  = alu_q.b;
  assign bus.aluOperation = alu_q.op;
  assign bus.respValid    = resp_valid;
  assign bus.respId       = resp_id;
  assign bus.respResult   = resp_result;
  assign bus.respZero     = resp_zero;
  assign bus.respError    = resp_error;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

  // Wrapping per-requester accepted-command counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (bus.reqValid0 && ready0_c) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (bus.reqValid1 && ready1_c) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end

  assign bus.grantCount0 = grant_cnt0;
  assign bus.grantCount1 = grant_cnt1;
`else
  assign bus.grantCount0 = '0;
  assign bus.grantCount1 = '0;
`endif
endmodule
